// File: rtl/video_timing_probe.sv
// Measures line and field timing on ce_pix cycles and publishes h/v totals,
// active sizes and an interlace flag once enough consecutive fields agree.
module video_timing_probe #(
  parameter int CNT_W         = 12,
  parameter int STABLE_FRAMES = 2
) (
  input  logic             clk_vid,
  input  logic             reset_n,
  input  logic             ce_pix,
  input  logic             de,
  input  logic             hs,
  input  logic             vs,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] h_active,
  output logic [CNT_W-1:0] v_total,
  output logic [CNT_W-1:0] v_active,
  output logic             interlaced,
  output logic             valid,
  output logic             changed
);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
  localparam int                 MATCH_W   = $clog2(STABLE_FRAMES + 1) + 1;
  localparam logic [MATCH_W-1:0] MATCH_TGT = MATCH_W'(STABLE_FRAMES);

  typedef enum logic [1:0] {IDLE, MEASURE, TRACK} state_e;

  typedef struct packed {
    logic [CNT_W-1:0] ht;
    logic [CNT_W-1:0] ha;
    logic [CNT_W-1:0] vt;
    logic [CNT_W-1:0] va;
    logic             il;
  } timing_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] max_cnt(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic diff_is_one(input logic [CNT_W-1:0] a,
                                       input logic [CNT_W-1:0] b);
    return (a > b) ? ((a - b) == CNT_W'(1)) : ((b - a) == CNT_W'(1));
  endfunction

  logic               hs_d_q, hs_d_d, vs_d_q, vs_d_d;
  logic [CNT_W-1:0]   hcnt_q, hcnt_d, dcnt_q, dcnt_d;
  logic [CNT_W-1:0]   htot_f_q, htot_f_d, hact_f_q, hact_f_d;
  logic [CNT_W-1:0]   vcnt_q, vcnt_d, acnt_q, acnt_d;
  logic               bad_q, bad_d;
  logic [CNT_W-1:0]   prev_vt_q, prev_vt_d, prev_va_q, prev_va_d;
  logic               prev_bad_q, prev_bad_d;
  state_e             state_q, state_d;
  logic               first_q, first_d;
  timing_t            cand_q, cand_d, pub_q, pub_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic               valid_q, valid_d, changed_q, changed_d, pubd_q, pubd_d;

  logic               hs_rise, vs_rise, fld_bad, cand_bad;
  logic [CNT_W-1:0]   line_tot, line_act;
  timing_t            cand;
  logic [MATCH_W-1:0] match_nxt;

  always_ff @(posedge clk_vid) begin
    if (!reset_n) begin
      hs_d_q     <= 1'b0;
      vs_d_q     <= 1'b0;
      hcnt_q     <= '0;
      dcnt_q     <= '0;
      htot_f_q   <= '0;
      hact_f_q   <= '0;
      vcnt_q     <= '0;
      acnt_q     <= '0;
      bad_q      <= 1'b0;
      prev_vt_q  <= '0;
      prev_va_q  <= '0;
      prev_bad_q <= 1'b0;
      state_q    <= IDLE;
      first_q    <= 1'b0;
      cand_q     <= '0;
      pub_q      <= '0;
      match_q    <= '0;
      valid_q    <= 1'b0;
      changed_q  <= 1'b0;
      pubd_q     <= 1'b0;
    end else begin
      hs_d_q     <= hs_d_d;
      vs_d_q     <= vs_d_d;
      hcnt_q     <= hcnt_d;
      dcnt_q     <= dcnt_d;
      htot_f_q   <= htot_f_d;
      hact_f_q   <= hact_f_d;
      vcnt_q     <= vcnt_d;
      acnt_q     <= acnt_d;
      bad_q      <= bad_d;
      prev_vt_q  <= prev_vt_d;
      prev_va_q  <= prev_va_d;
      prev_bad_q <= prev_bad_d;
      state_q    <= state_d;
      first_q    <= first_d;
      cand_q     <= cand_d;
      pub_q      <= pub_d;
      match_q    <= match_d;
      valid_q    <= valid_d;
      changed_q  <= changed_d;
      pubd_q     <= pubd_d;
    end
  end

  always_comb begin
    hs_d_d     = hs_d_q;
    vs_d_d     = vs_d_q;
    hcnt_d     = hcnt_q;
    dcnt_d     = dcnt_q;
    htot_f_d   = htot_f_q;
    hact_f_d   = hact_f_q;
    vcnt_d     = vcnt_q;
    acnt_d     = acnt_q;
    bad_d      = bad_q;
    prev_vt_d  = prev_vt_q;
    prev_va_d  = prev_va_q;
    prev_bad_d = prev_bad_q;
    state_d    = state_q;
    first_d    = first_q;
    cand_d     = cand_q;
    pub_d      = pub_q;
    match_d    = match_q;
    valid_d    = valid_q;
    changed_d  = 1'b0;
    pubd_d     = pubd_q;
    hs_rise    = hs & ~hs_d_q;
    vs_rise    = vs & ~vs_d_q;
    line_tot   = sat_inc(hcnt_q);
    line_act   = dcnt_q;
    fld_bad    = 1'b0;
    cand_bad   = 1'b0;
    cand       = '0;
    match_nxt  = '0;

    if (ce_pix) begin
      hs_d_d = hs;
      vs_d_d = vs;
      // A line closes before its field so a coincident hs/vs edge counts in the closing field.
      if (hs_rise) begin
        hcnt_d   = '0;
        dcnt_d   = CNT_W'(de);
        htot_f_d = line_tot;
        hact_f_d = max_cnt(hact_f_q, line_act);
        vcnt_d   = sat_inc(vcnt_q);
        if (line_act != '0) acnt_d = sat_inc(acnt_q);
      end else begin
        hcnt_d = sat_inc(hcnt_q);
        if (de) dcnt_d = sat_inc(dcnt_q);
      end
      bad_d = bad_q | (hcnt_d == CNT_MAX) | (dcnt_d == CNT_MAX) |
              (vcnt_d == CNT_MAX) | (acnt_d == CNT_MAX) |
              (hs_rise && (line_tot == CNT_MAX));

      if (vs_rise) begin
        fld_bad  = bad_d;
        cand.ht  = htot_f_d;
        cand.ha  = hact_f_d;
        cand.vt  = max_cnt(vcnt_d, prev_vt_q);
        cand.va  = max_cnt(acnt_d, prev_va_q);
        cand.il  = diff_is_one(vcnt_d, prev_vt_q);
        cand_bad = fld_bad | prev_bad_q;
        match_nxt = (match_q >= MATCH_TGT) ? MATCH_TGT : match_q + 1'b1;

        prev_vt_d  = vcnt_d;
        prev_va_d  = acnt_d;
        prev_bad_d = fld_bad;
        vcnt_d     = '0;
        acnt_d     = '0;
        hact_f_d   = '0;
        bad_d      = 1'b0;

        unique case (state_q)
          IDLE: begin
            state_d = MEASURE;
            first_d = 1'b0;
          end
          MEASURE: begin
            if (!first_q) begin
              first_d = 1'b1;
            end else begin
              cand_d  = cand;
              match_d = '0;
              state_d = TRACK;
            end
          end
          default: begin
            cand_d = cand;
            if ((cand == cand_q) && !cand_bad) begin
              match_d = match_nxt;
              if (match_nxt == MATCH_TGT) begin
                pub_d     = cand;
                valid_d   = 1'b1;
                changed_d = (cand != pub_q) || !pubd_q;
                pubd_d    = 1'b1;
              end
            end else begin
              match_d = '0;
              valid_d = 1'b0;
            end
          end
        endcase
      end
    end
  end

  assign h_total    = pub_q.ht;
  assign h_active   = pub_q.ha;
  assign v_total    = pub_q.vt;
  assign v_active   = pub_q.va;
  assign interlaced = pub_q.il;
  assign valid      = valid_q;
  assign changed    = changed_q;
endmodule

// File: tb/tb_video_timing_probe.sv
// Randomised field-level bench for video_timing_probe against a per-field
// reference model of the published timing.
module tb_video_timing_probe;
  localparam int CW    = 8;
  localparam int SF    = 2;
  localparam int MAXV  = (1 << CW) - 1;

  logic          clk_vid = 1'b0;
  logic          reset_n = 1'b0;
  logic          ce_pix = 1'b0, de = 1'b0, hs = 1'b0, vs = 1'b0;
  logic [CW-1:0] h_total, h_active, v_total, v_active;
  logic          interlaced, valid, changed;

  video_timing_probe #(.CNT_W(CW), .STABLE_FRAMES(SF)) dut (
    .clk_vid(clk_vid), .reset_n(reset_n), .ce_pix(ce_pix), .de(de), .hs(hs), .vs(vs),
    .h_total(h_total), .h_active(h_active), .v_total(v_total), .v_active(v_active),
    .interlaced(interlaced), .valid(valid), .changed(changed)
  );

  always #5 clk_vid = ~clk_vid;

  typedef struct { int ht; int ha; int vt; int va; bit bad; } field_t;

  int     n_cmp = 0, n_mis = 0, n_chg_seen = 0;
  int     idle_min = 0, idle_max = 0;
  field_t last_f = '{0, 0, 0, 0, 1'b0};

  // Reference: what should be published, derived from whole-field summaries.
  field_t m_prev;
  int     m_nvs, m_match, m_nchg = 0;
  int     m_pub[5], m_cand[5];
  bit     m_valid, m_pubd, m_changed;

  always @(negedge clk_vid) if (changed === 1'b1) n_chg_seen++;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic void model_reset();
    m_nvs = 0; m_match = 0; m_valid = 0; m_pubd = 0; m_changed = 0;
    for (int i = 0; i < 5; i++) begin m_pub[i] = 0; m_cand[i] = 0; end
  endfunction

  function automatic void model_vs(input field_t f);
    int  c[5];
    bit  same, differs;
    m_changed = 0;
    m_nvs++;
    if (m_nvs >= 3) begin
      c[0] = f.ht;
      c[1] = f.ha;
      c[2] = imax(f.vt, m_prev.vt);
      c[3] = imax(f.va, m_prev.va);
      c[4] = ((f.vt - m_prev.vt == 1) || (m_prev.vt - f.vt == 1)) ? 1 : 0;
      same = 1;
      for (int i = 0; i < 5; i++) if (c[i] != m_cand[i]) same = 0;
      if (m_nvs == 3) begin
        m_match = 0;
      end else if (same && !f.bad && !m_prev.bad) begin
        m_match = (m_match + 1 > SF) ? SF : m_match + 1;
        if (m_match == SF) begin
          differs = 0;
          for (int i = 0; i < 5; i++) if (c[i] != m_pub[i]) differs = 1;
          m_changed = differs || !m_pubd;
          if (m_changed) m_nchg++;
          for (int i = 0; i < 5; i++) m_pub[i] = c[i];
          m_valid = 1;
          m_pubd  = 1;
        end
      end else begin
        m_match = 0;
        m_valid = 0;
      end
      for (int i = 0; i < 5; i++) m_cand[i] = c[i];
    end
    m_prev = f;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, ".h_total"},    32'(h_total),    m_pub[0]);
    check_val({tag, ".h_active"},   32'(h_active),   m_pub[1]);
    check_val({tag, ".v_total"},    32'(v_total),    m_pub[2]);
    check_val({tag, ".v_active"},   32'(v_active),   m_pub[3]);
    check_val({tag, ".interlaced"}, 32'(interlaced), m_pub[4]);
    check_val({tag, ".valid"},      32'(valid),      32'(m_valid));
    check_val({tag, ".changed"},    32'(changed),    32'(m_changed));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      ce_pix = 1'b0;
      hs = 1'($urandom); vs = 1'($urandom); de = 1'($urandom);
      @(posedge clk_vid); #1;
    end
  endtask

  task automatic reset_cycle(input string tag);
    ce_pix = 1'b0;
    reset_n = 1'b0;
    @(posedge clk_vid); #1;
    reset_n = 1'b1;
    model_reset();
    check_outputs(tag);
  endtask

  task automatic drive_field(input int ht, input int nl, input int a0, input int na,
                             input int hact, input int stall_line, input int rst_line);
    for (int l = 0; l < nl; l++) begin
      for (int p = 0; p < ht; p++) begin
        if (l == stall_line && p == 10) begin
          idle_cycles(1000);
          check_outputs("stall");
        end
        if (l == rst_line && p == 10) reset_cycle("midreset");
        ce_pix = 1'b1;
        hs = (p < 4);
        vs = (l < 2);
        de = (l >= a0) && (l < a0 + na) && (p >= 6) && (p < 6 + hact);
        @(posedge clk_vid); #1;
        if (l == 0 && p == 0) begin
          model_vs(last_f);
          check_outputs("field");
        end
        idle_cycles($urandom_range(idle_min, idle_max));
      end
    end
    last_f = '{ht, (na > 0) ? hact : 0, nl, na, (ht >= MAXV)};
  endtask

  initial begin
    int ht, nl, na, a0, hact;
    model_reset();
    m_prev = '{0, 0, 0, 0, 1'b0};
    repeat (3) @(posedge clk_vid);
    #1;
    check_outputs("reset");
    reset_n = 1'b1;

    // Over-long lines saturate the pixel counter: nothing may ever publish.
    idle_min = 0; idle_max = 0;
    for (int f = 0; f < 6; f++) drive_field(300, 4, 2, 1, 20, -1, -1);
    check_val("sat.valid", 32'(valid), 0);
    check_val("sat.h_total", 32'(h_total), 0);
    reset_cycle("reset2");

    // Progressive, pixel enable every second clock.
    idle_min = 1; idle_max = 1;
    for (int f = 0; f < 6; f++) drive_field(40, 16, 3, 10, 24, -1, -1);
    check_val("prog.h_total", 32'(h_total), 40);
    check_val("prog.h_active", 32'(h_active), 24);
    check_val("prog.v_total", 32'(v_total), 16);
    check_val("prog.v_active", 32'(v_active), 10);
    check_val("prog.valid", 32'(valid), 1);

    // Long pixel-enable stall mid-line must change nothing.
    idle_min = 0; idle_max = 1;
    drive_field(40, 16, 3, 10, 24, 5, -1);
    drive_field(40, 16, 3, 10, 24, -1, -1);
    check_val("stall.valid", 32'(valid), 1);

    // Line length change: drop valid, then republish the new timing.
    for (int f = 0; f < 4; f++) drive_field(50, 16, 3, 10, 24, -1, -1);
    check_val("switch.h_total", 32'(h_total), 50);
    check_val("switch.valid", 32'(valid), 1);

    // Alternating 15/16-line fields.
    for (int f = 0; f < 6; f++) drive_field(45, (f % 2 == 0) ? 15 : 16, 4, 8, 30, -1, -1);
    check_val("intl.v_total", 32'(v_total), 16);
    check_val("intl.interlaced", 32'(interlaced), 1);
    check_val("intl.valid", 32'(valid), 1);

    // Random progressive formats.
    idle_min = 0; idle_max = 2;
    for (int r = 0; r < 3; r++) begin
      ht   = $urandom_range(30, 50);
      nl   = $urandom_range(12, 18);
      na   = $urandom_range(0, nl - 3);
      a0   = $urandom_range(2, nl - na);
      hact = $urandom_range(1, ht - 8);
      for (int f = 0; f < 5; f++) drive_field(ht, nl, a0, na, hact, -1, -1);
    end

    // Reset during a steady field, then reacquire.
    idle_min = 0; idle_max = 1;
    drive_field(40, 16, 3, 10, 24, -1, -1);
    drive_field(40, 16, 3, 10, 24, -1, 3);
    for (int f = 0; f < 5; f++) drive_field(40, 16, 3, 10, 24, -1, -1);
    check_val("reacq.valid", 32'(valid), 1);
    check_val("reacq.h_total", 32'(h_total), 40);

    idle_cycles(5);
    check_val("changed_pulses", n_chg_seen, m_nchg);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/video_timing_probe.md
# video_timing_probe

Measures the pixel-domain video timing produced by the core (after sync polarity normalisation) and publishes stable horizontal/vertical totals, active sizes and an interlace flag. Sits directly downstream of the sync polarity fixer on the core video path (ce_pix, de, hs, vs, clocked by clk_vid). Its results feed the HPS status readback and the scaler configuration. It reports only settled timing: values are published after several consecutive identical fields.

## Interface
- CNT_W, 12: width of all pixel/line counters and outputs.
- STABLE_FRAMES, 2: number of consecutive matching candidates required before publishing.

- clk_vid  in  1  video clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- ce_pix  in  1  pixel enable; inputs are sampled and counters advance only when 1.
- de  in  1  data enable, active high.
- hs  in  1  hsync, active high (polarity already normalised).
- vs  in  1  vsync, active high (polarity already normalised).
- h_total  out  CNT_W  pixels per line.
- h_active  out  CNT_W  max de pixels in any line of the field.
- v_total  out  CNT_W  lines per field (max of last two fields).
- v_active  out  CNT_W  lines with de (max of last two fields).
- interlaced  out  1  consecutive field line counts differ by exactly 1.
- valid  out  1  published values reflect current stable timing.
- changed  out  1  one-cycle pulse when a new published set differs from the previous one.

## Operation
- Edge detection on ce_pix cycles only: hs_rise = hs & ~hs_d, vs_rise = vs & ~vs_d; hs_d/vs_d update only when ce_pix=1.
- Horizontal: hcnt cleared to 0 on an hs_rise pixel, +1 on every other pixel. At hs_rise, line_total = hcnt+1. dcnt counts de=1 pixels from the hs_rise pixel (inclusive) to the pixel before the next hs_rise. At hs_rise, line_active = dcnt, and dcnt restarts at de?1:0.
- Per field: h_total_f = last line_total. h_active_f = max line_active. vcnt +1 per hs_rise. acnt +1 per hs_rise with line_active≠0.
- Simultaneous hs_rise and vs_rise: the line closes first (its increments count in the closing field), then the field closes.
- At vs_rise: field_vt = vcnt, field_va = acnt. Then vcnt, acnt and h_active_f are cleared.
- Saturation: every counter sticks at all-ones. A field with any saturated counter is marked bad.
- Candidate: formed at each field close once two fields exist.
  - h_total = h_total_f; h_active = h_active_f.
  - v_total = max(field_vt[n], field_vt[n-1]); v_active likewise.
  - interlaced = |field_vt[n] − field_vt[n-1]| == 1.
- States:
  - IDLE (reset): wait for the first vs_rise → MEASURE.
  - MEASURE: accumulate; each vs_rise closes a field. After the second closed field → TRACK, match=0.
  - TRACK: each vs_rise forms a candidate. Equal to the previous candidate (all five fields) and not bad → match+1. Otherwise match=0, valid=0; published outputs hold.
  - When match reaches STABLE_FRAMES: publish, valid=1, match holds. changed=1 for one cycle if the published set differs from the prior published set. The first publication after reset pulses changed.

## Timing
- Reset: all outputs 0, state IDLE, match 0, all counters 0.
- Outputs, valid and changed update 1 clk_vid cycle after the ce_pix cycle sampling the qualifying vs_rise. changed is coincident with the new values.
- ce_pix=0 cycles: no state change whatsoever.
- With STABLE_FRAMES=2, first valid=1 follows the 5th vs_rise after reset: #1 start, #2/#3 fields, #3 candidate 1, #4 match 1, #5 match 2.
- reset_n low mid-field: the next cycle is as after reset. No partial field is retained.

## Test plan
- Progressive 800×525, 640 de px on lines 36–515, ce_pix every 2nd clock → after vs_rise #5: h_total=800, h_active=640, v_total=525, v_active=480, interlaced=0, valid=1, changed pulse once.
- Alternating 262/263-line fields, 858 px/line, 720 active → v_total=263, interlaced=1, valid=1.
- Stable 800×525, then switch to 858 px/line → valid=0 at the first mismatching field close, outputs held. Two matching candidates later: h_total=858, valid=1, changed pulse.
- ce_pix held low 1000 clocks mid-line during steady state → no output change, valid stays 1.
- Line period 5000 px (CNT_W=12) → every candidate bad, valid stays 0, outputs remain 0.
- reset_n low one cycle during field 4 of steady 800×525 → all outputs 0 next cycle. valid=1 again at vs_rise #5 after release.
